sprite_compositor: RTL

- Sits directly downstream of the player/obstacle sprite controllers. Each controller writes a 32-bit sprite descriptor (dina) into a slot (addr).
- Holds an 8-entry double-buffered sprite attribute table. For every VGA pixel it selects the highest-priority sprite and fetches its texel from the sprite sheet ROM. It outputs the pixel colour, with transparency keying applied, two cycles later.
- Also reports a per-frame bounding-box collision between slot 0 (player) and any other slot. This feeds the top-level game_over logic.

---
 rtl/sprite_compositor.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor
// Eight-slot double-buffered sprite attribute table feeding a two-stage
// pixel pipeline: stage 1 picks the lowest-index sprite covering the
// current pixel and addresses the sprite sheet ROM; stage 2 applies the
// transparency key and registers the composited colour (latency 2).
// Also reports a once-per-frame bounding-box collision between slot 0
// (player) and any other slot.
//
// Optional build macro: SPRITE_FLIP_EN
//   defined   -> descriptor bit 26 mirrors the sprite horizontally
//   undefined -> bit 26 is ignored (reserved)
//
// Handshake: there is no valid/ready flow control. Descriptor writes are
// accepted unconditionally on any cycle with we=1; pixel inputs are
// consumed every cycle and pix_valid/pix_rgb follow exactly two cycles later.

module sprite_compositor #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    parameter logic [11:0] BG_RGB      = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] dina,
    input  logic        vsync_start,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        video_on,
    output logic [15:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic        pix_valid,
    output logic [11:0] pix_rgb,
    output logic        collide
);

    localparam int DXW = $clog2(SPR_W);
    localparam int DYW = $clog2(SPR_H);

    // Descriptor tables: shadow is written by the controllers, active is
    // what the pixel pipeline reads, so geometry only changes per frame.
    logic [31:0] shadow [8];
    logic [31:0] active [8];

    // Stage-1 combinational results
    logic [7:0]     slot_hit;
    logic           win_hit;
    logic [2:0]     win_idx;
    logic [31:0]    win_desc;
    logic [9:0]     dx_raw;
    logic [9:0]     dy_raw;
    logic [DXW-1:0] dx_sel;
    logic [15:0]    next_rom_addr;
    logic           coll_now;

    // Pipeline and collision state
    logic hit_s1;
    logic von_s1;
    logic coll_acc;

    // Descriptor writes into shadow; vsync copies shadow to active, with a
    // same-cycle write forwarded straight into the active slot as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (vsync_start) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (we) begin
                shadow[addr] <= dina;
                if (vsync_start) begin
                    active[addr] <= dina;
                end
            end
        end
    end

    // Bounding-box test per slot, with 11-bit sums so sprites near the
    // right/bottom edge clip instead of wrapping to column/row 0.
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < 8; i++) begin
            slot_hit[i] = active[i][31]
                && ({1'b0, h_cnt} >= {1'b0, active[i][25:16]})
                && ({1'b0, h_cnt} <  ({1'b0, active[i][25:16]} + 11'(SPR_W)))
                && ({1'b0, v_cnt} >= {1'b0, active[i][15:6]})
                && ({1'b0, v_cnt} <  ({1'b0, active[i][15:6]} + 11'(SPR_H)));
        end
    end

    // Lowest-index hitting slot has priority.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (slot_hit[i]) begin
                win_hit = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    // Texel coordinates inside the winning sprite and the ROM address.
    always_comb begin
        win_desc = active[win_idx];
        dx_raw   = h_cnt - win_desc[25:16];
        dy_raw   = v_cnt - win_desc[15:6];
`ifdef SPRITE_FLIP_EN
        dx_sel = win_desc[26] ? (DXW'(SPR_W - 1) - dx_raw[DXW-1:0]) : dx_raw[DXW-1:0];
`else
        dx_sel = dx_raw[DXW-1:0];
`endif
        next_rom_addr = 16'({win_desc[5:3], win_desc[2:0], dy_raw[DYW-1:0], dx_sel});
        coll_now      = video_on && slot_hit[0] && (|slot_hit[7:1]);
    end

    // Bits that do not take part in the datapath (reserved fields, high
    // bits of the offsets) are gathered here to keep lint quiet.
    logic unused_bits;
    assign unused_bits = ^{win_desc[30:26], dx_raw, dy_raw};

    // Stage 1: register ROM address (held when nothing hits), hit and video_on.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            hit_s1   <= 1'b0;
            von_s1   <= 1'b0;
        end else begin
            if (win_hit) begin
                rom_addr <= next_rom_addr;
            end
            hit_s1 <= win_hit;
            von_s1 <= video_on;
        end
    end

    // Stage 2: key out transparent texels; transparency shows background,
    // never a lower-priority sprite.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_rgb   <= BG_RGB;
        end else begin
            pix_valid <= von_s1;
            if (von_s1 && hit_s1 && (rom_data != TRANSPARENT)) begin
                pix_rgb <= rom_data;
            end else begin
                pix_rgb <= BG_RGB;
            end
        end
    end

    // Collision accumulator: collects overlaps during the frame and is
    // published on vsync (including an overlap seen on the vsync cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_acc <= 1'b0;
            collide  <= 1'b0;
        end else if (vsync_start) begin
            collide  <= coll_acc | coll_now;
            coll_acc <= 1'b0;
        end else begin
            coll_acc <= coll_acc | coll_now;
        end
    end

endmodule
